// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - AArch64 instruction-fetch stage with one-entry buffer and redirect draining
module fetch_unit #(
    parameter int                PC_W     = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ireq_valid,
    output logic [PC_W-1:0]    ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    saved_pc;
    logic [PC_W-1:0]    buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic               buf_valid;

    // Redirect targets are always word aligned; the low bits are dropped.
    logic [PC_W-1:0]    target;
    logic               unused_low_bits;
    assign target          = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    // Fetch sequencing: REQ waits for the bus, HOLD presents the buffer,
    // DRAIN lets a read that a redirect made stale finish before refetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            saved_pc  <= '0;
            buf_pc    <= '0;
            buf_instr <= '0;
            buf_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        // The bus cannot abort, so a read still in flight must drain.
                        if (iresp_data_ok) begin
                            pc <= target;
                        end else begin
                            saved_pc <= target;
                            state    <= S_DRAIN;
                        end
                    end else if (iresp_data_ok) begin
                        buf_pc    <= pc;
                        buf_instr <= iresp_data;
                        buf_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc        <= target;
                        buf_valid <= 1'b0;
                        state     <= S_REQ;
                    end else if (!stall) begin
                        pc        <= pc + PC_W'(4);
                        buf_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (iresp_data_ok) begin
                        // Stale data is dropped; a same-cycle redirect beats the saved target.
                        pc    <= redirect ? target : saved_pc;
                        state <= S_REQ;
                    end else if (redirect) begin
                        saved_pc <= target;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // pc is left untouched while draining, so it still names the stale read.
    assign ireq_valid = !rst && (state != S_HOLD);
    assign ireq_addr  = pc;
    assign out_valid  = buf_valid;
    assign out_pc     = buf_pc;
    assign out_instr  = buf_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus randomized bus/redirect run against a transaction model
module tb_fetch_unit;

    localparam logic [63:0] R  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] I0 = 32'hD503_201F;
    localparam logic [31:0] I1 = 32'h9100_0421;
    localparam logic [31:0] I2 = 32'hAA01_03E2;
    localparam logic [31:0] I3 = 32'h1111_1111;
    localparam logic [31:0] I4 = 32'h2222_2222;
    localparam logic [31:0] I5 = 32'h5280_0020;
    localparam logic [31:0] I6 = 32'h3333_3333;
    localparam logic [31:0] I7 = 32'h4444_4444;
    localparam int          RAND_CYCLES = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir;
        logic [63:0] rpc;
        logic        dok;
        logic [31:0] data;
        logic        check;
        logic        ev;
        logic [63:0] ea;
        logic        ov;
        logic        cd;
        logic [63:0] epc;
        logic [31:0] ein;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic s, input logic rd, input logic [63:0] rp,
                       input logic dk, input logic [31:0] d, input logic ck, input logic ev,
                       input logic [63:0] ea, input logic ov, input logic cd,
                       input logic [63:0] epc, input logic [31:0] ein);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.dok = dk; v.data = d;
        v.check = ck; v.ev = ev; v.ea = ea; v.ov = ov; v.cd = cd; v.epc = epc; v.ein = ein;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'hA5C3_0F69;
    endfunction

    // transaction-level reference state for the random run
    logic        m_presenting, m_busy, m_stale, m_dok, m_pres_before, m_ok;
    logic [63:0] m_exp_pc, m_req_addr;
    int          m_remaining, m_accepted;

    initial begin
        // reset, stall x3 on the first word, zero-wait stream
        add(1,0,0,0,0,0,  0, 0,0, 0, 0,0,0);
        add(1,0,0,0,0,0,  1, 0,0, 0, 1,0,0);
        add(0,0,0,0,1,I0, 1, 1,R, 0, 1,0,0);
        add(0,1,0,0,0,0,  1, 0,0, 1, 1,R,I0);
        add(0,1,0,0,0,0,  1, 0,0, 1, 1,R,I0);
        add(0,1,0,0,0,0,  1, 0,0, 1, 1,R,I0);
        add(0,0,0,0,0,0,  1, 0,0, 1, 1,R,I0);
        add(0,0,0,0,1,I1, 1, 1,R+4, 0, 0,0,0);
        add(0,0,0,0,0,0,  1, 0,0, 1, 1,R+4,I1);
        add(0,0,0,0,1,I2, 1, 1,R+8, 0, 0,0,0);
        // redirect in HOLD while stalled; target low bits dropped
        add(0,1,1,64'h8000_1002,0,0, 1, 0,0, 1, 1,R+8,I2);
        add(0,0,0,0,0,0,  1, 1,64'h8000_1000, 0, 1,R+8,I2);
        // 5-cycle read with two redirects; address held, data dropped, last target wins
        add(0,0,1,64'h9000_0000,0,0, 1, 1,64'h8000_1000, 0, 0,0,0);
        add(0,0,0,0,0,0,  1, 1,64'h8000_1000, 0, 0,0,0);
        add(0,0,1,64'hA000_0000,0,0, 1, 1,64'h8000_1000, 0, 0,0,0);
        add(0,0,0,0,1,I3, 1, 1,64'h8000_1000, 0, 0,0,0);
        // redirect together with data_ok in REQ
        add(0,0,1,64'hFFFF_FFFF_FFFF_FFFC,1,I4, 1, 1,64'hA000_0000, 0, 1,R+8,I2);
        add(0,0,0,0,1,I5, 1, 1,64'hFFFF_FFFF_FFFF_FFFC, 0, 0,0,0);
        // accept at the top of the address space wraps to zero
        add(0,0,0,0,0,0,  1, 0,0, 1, 1,64'hFFFF_FFFF_FFFF_FFFC,I5);
        add(0,0,1,64'h4000_0008,0,0, 1, 1,64'h0, 0, 0,0,0);
        add(0,0,0,0,1,I6, 1, 1,64'h0, 0, 1,64'hFFFF_FFFF_FFFF_FFFC,I5);
        // DRAIN with redirect and data_ok in the same cycle
        add(0,0,1,64'h5000_0000,0,0, 1, 1,64'h4000_0008, 0, 0,0,0);
        add(0,0,1,64'h6000_0004,1,I7, 1, 1,64'h4000_0008, 0, 0,0,0);
        add(0,0,1,64'h7000_0000,0,0, 1, 1,64'h6000_0004, 0, 0,0,0);
        // reset while draining
        add(1,0,0,0,0,0,  1, 0,0, 0, 0,0,0);
        add(1,0,0,0,0,0,  1, 0,0, 0, 1,0,0);
        add(0,0,0,0,1,I0, 1, 1,R, 0, 1,0,0);
        add(0,0,0,0,0,0,  1, 0,0, 1, 1,R,I0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; iresp_data_ok = vecs[i].dok; iresp_data = vecs[i].data;
            #1;
            if (vecs[i].check) begin
                n_vec++;
                m_ok = (ireq_valid === vecs[i].ev) && (!vecs[i].ev || ireq_addr === vecs[i].ea) &&
                       (out_valid === vecs[i].ov) &&
                       (!vecs[i].cd || (out_pc === vecs[i].epc && out_instr === vecs[i].ein));
                if (!m_ok) begin
                    n_bad++;
                    $display("FAIL vec %0d: got iv=%b addr=%h ov=%b pc=%h instr=%h, want iv=%b addr=%h ov=%b pc=%h instr=%h (pc/instr checked=%b)",
                             i, ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
                             vecs[i].ev, vecs[i].ea, vecs[i].ov, vecs[i].epc, vecs[i].ein, vecs[i].cd);
                end
            end
        end

        // randomized run: bus with 0..4 extra wait cycles, random stall/redirect/reset
        m_presenting = 0; m_busy = 0; m_stale = 0; m_exp_pc = R; m_req_addr = '0;
        m_remaining = 0; m_accepted = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            @(negedge clk);
            rst = (c < 2) || ($urandom_range(0, 99) == 0);
            #1;
            m_pres_before = m_presenting;
            n_vec++;
            if (ireq_valid !== (!rst && !m_presenting)) begin
                n_bad++;
                $display("FAIL rand ireq_valid cyc %0d: got %b want %b", c, ireq_valid, !rst && !m_presenting);
            end
            if (!rst) begin
                if (m_busy) begin
                    n_vec++;
                    if (ireq_valid !== 1'b1 || ireq_addr !== m_req_addr) begin
                        n_bad++;
                        $display("FAIL rand req_hold cyc %0d: got iv=%b addr=%h want iv=1 addr=%h", c, ireq_valid, ireq_addr, m_req_addr);
                    end
                end else if (ireq_valid === 1'b1) begin
                    m_busy = 1; m_stale = 0; m_req_addr = ireq_addr;
                    m_remaining = $urandom_range(0, 4);
                    n_vec++;
                    if (ireq_addr !== m_exp_pc) begin
                        n_bad++;
                        $display("FAIL rand req_addr cyc %0d: got %h want %h", c, ireq_addr, m_exp_pc);
                    end
                end
            end
            if (c >= 2) begin
                n_vec++;
                if (out_valid !== m_presenting) begin
                    n_bad++;
                    $display("FAIL rand out_valid cyc %0d: got %b want %b", c, out_valid, m_presenting);
                end
                if (m_presenting) begin
                    n_vec++;
                    if (out_pc !== m_exp_pc || out_instr !== mem_word(m_exp_pc)) begin
                        n_bad++;
                        $display("FAIL rand out_data cyc %0d: got pc=%h instr=%h want pc=%h instr=%h",
                                 c, out_pc, out_instr, m_exp_pc, mem_word(m_exp_pc));
                    end
                end
            end

            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            else
                redirect_pc = {$urandom, $urandom};
            m_dok = !rst && m_busy && (m_remaining == 0);
            iresp_data_ok = m_dok;
            iresp_data    = m_dok ? mem_word(m_req_addr) : $urandom;

            if (rst) begin
                m_presenting = 0; m_busy = 0; m_stale = 0; m_exp_pc = R;
            end else begin
                if (m_busy && redirect) m_stale = 1;
                if (m_dok) begin
                    m_busy = 0;
                    if (!m_stale) m_presenting = 1;
                end else if (m_busy) begin
                    m_remaining--;
                end
                if (m_pres_before && (redirect || !stall)) m_presenting = 0;
                if (redirect) m_exp_pc = {redirect_pc[63:2], 2'b00};
                else if (m_pres_before && !stall) begin
                    m_exp_pc = m_exp_pc + 64'd4;
                    m_accepted++;
                end
            end
        end

        n_vec++;
        if (m_accepted < 50) begin
            n_bad++;
            $display("FAIL rand progress: got %0d accepted instructions, want at least 50", m_accepted);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the AArch64 pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues 32-bit instruction reads on the instruction bus with a valid/data_ok handshake.
- Buffers one returned instruction until the decode side accepts it, and presents {valid, pc, instr} as the IF/ID register's input.
- Handles branch/exception redirects, including redirects that arrive while a bus read is still outstanding.

Parameters:
- PC_W, 64, width of PC and bus address.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode side not accepting this cycle (IF/ID enable low).
- redirect  in  1  redirect request from execute/commit.
- redirect_pc  in  PC_W  redirect target.
- ireq_valid  out  1  instruction read request.
- ireq_addr  out  PC_W  read address; 4-byte aligned.
- iresp_data_ok  in  1  read completes this cycle.
- iresp_data  in  INSTR_W  read data; valid when iresp_data_ok=1.
- out_valid  out  1  out_pc/out_instr hold a real instruction; 0 means bubble.
- out_pc  out  PC_W  PC of the presented instruction.
- out_instr  out  INSTR_W  presented instruction.

Behaviour:
- Clock/reset:
  - Single clock clk.
  - rst is synchronous and active-high. When sampled high: state←REQ, pc←RESET_PC, buffer cleared, saved target cleared.
- Output values in the cycle after reset and while rst is held:
  - ireq_valid=0, out_valid=0, out_pc=0, out_instr=0.
  - ireq_valid is gated by rst.
  - The first request, at RESET_PC, is issued in the first cycle with rst=0.
- States: REQ (read outstanding), HOLD (instruction buffered), DRAIN (stale read outstanding after a redirect).
- Bus rule:
  - ireq_valid=1 in REQ and DRAIN, 0 in HOLD.
  - Once asserted, ireq_valid and ireq_addr stay stable until the cycle with iresp_data_ok=1. There is no abort.
  - ireq_addr = pc in REQ, and the stale address in DRAIN.
  - iresp_data_ok is ignored in HOLD.
- REQ:
  - On iresp_data_ok with no redirect: buffer←{pc, iresp_data}, go to HOLD.
  - out_valid=1 the next cycle, giving a latency of 1 cycle from data_ok.
- HOLD:
  - out_valid=1; out_pc/out_instr come from the buffer.
  - If stall=0 (accepted): pc←pc+4 (mod 2^PC_W, wraps silently), go to REQ.
  - If stall=1: hold everything unchanged, for any number of cycles.
- Outside HOLD: out_valid=0, and out_pc/out_instr keep their last values.
- Redirect rules (redirect has top priority):
  - The target's low 2 bits are forced to 0.
  - HOLD+redirect: discard the buffer and ignore stall. pc←target, go to REQ. out_valid=0 the next cycle.
  - REQ+redirect with iresp_data_ok the same cycle: discard the data, pc←target, stay in REQ. The new address appears the next cycle.
  - REQ+redirect without data_ok: saved←target, go to DRAIN.
  - DRAIN+redirect: saved←latest target; the last one wins.
  - DRAIN+iresp_data_ok (with no new redirect): discard the data, pc←saved, go to REQ.
  - DRAIN+redirect+iresp_data_ok in the same cycle: discard the data, pc←redirect target, go to REQ.
- A discarded instruction is never presented with out_valid=1.
- Throughput: at most 1 instruction per 2 cycles with a 1-cycle bus.
- Reset mid-operation: the outstanding read is abandoned. The instruction bus is reset by the same rst, so no late data_ok follows.

Test Plan:
- Reset then zero-wait bus (data_ok the cycle after request), stall=0:
  - ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - out_valid pulses every 2nd cycle with matching out_pc/out_instr.
- data_ok arrives with instr 0xD503201F, then stall held 3 cycles:
  - out_valid=1, out_pc=0x8000_0000, out_instr=0xD503201F stable for all 4 cycles.
  - No request during this time; next ireq_addr=0x8000_0004.
- Redirect to 0x8000_1002 while in HOLD with stall=1:
  - Buffer dropped, out_valid=0.
  - Next ireq_addr=0x8000_1000.
- Read outstanding with a 5-cycle bus; redirect to 0x9000_0000 at cycle 1, then to 0xA000_0000 at cycle 3:
  - Address stays at the old value until data_ok.
  - Data is discarded with out_valid never 1.
  - Next ireq_addr=0xA000_0000.
- Redirect and data_ok in the same REQ cycle:
  - Data discarded.
  - ireq_addr=target the next cycle.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted:
  - Next ireq_addr=0x0.
- rst asserted in DRAIN:
  - ireq_valid=0 and out_valid=0 while rst is held.
  - The first request after release is at RESET_PC.
